// File: rtl/lpgbt_uplink_capture.sv
// Triggered capture buffer for decoded lpGBT uplink frames.
// Records one channel slice, freezes a pre/post window and streams it out.
module lpgbt_uplink_capture #(
   parameter int FRAME_WIDTH = 234,
   parameter int NUM_CH      = 7,
   parameter int CH_WIDTH    = 32,
   parameter int DEPTH       = 256,
   parameter int AW          = $clog2(DEPTH),
   parameter int SW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clk40_i,
   input  logic                   rst_i,
   input  logic [FRAME_WIDTH-1:0] frame_i,
   input  logic                   frame_valid_i,
   input  logic                   fec_i,
   input  logic [SW-1:0]          ch_sel_i,
   input  logic                   arm_i,
   input  logic                   abort_i,
   input  logic [1:0]             trig_mode_i,
   input  logic                   trig_i,
   input  logic [CH_WIDTH-1:0]    pattern_i,
   input  logic [CH_WIDTH-1:0]    mask_i,
   input  logic [AW:0]            post_len_i,
   output logic [CH_WIDTH-1:0]    rd_data_o,
   output logic                   rd_valid_o,
   input  logic                   rd_ready_i,
   output logic                   rd_last_o,
   output logic [1:0]             state_o,
   output logic [AW:0]            capture_len_o,
   output logic [31:0]            fec_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_POST = 2'd2,
      S_READ = 2'd3
   } state_t;

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_L   = (AW+1)'(1);

   state_t              state_q, state_d;
   logic [SW-1:0]       ch_q, ch_d;
   logic [AW:0]         post_q, post_d;
   logic [AW:0]         pre_q, pre_d;
   logic [AW:0]         pcnt_q, pcnt_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]         rem_q, rem_d;
   logic                fetch_q, fetch_d;
   logic                rd_valid_q, rd_valid_d;
   logic                rd_last_q, rd_last_d;
   logic [AW:0]         cap_q, cap_d;
   logic [31:0]         fec_q, fec_d;
   logic [CH_WIDTH-1:0] rd_data_q;
   logic [CH_WIDTH-1:0] mem_q [DEPTH];

   logic [CH_WIDTH-1:0] word;
   logic                match;
   logic                trig;
   logic                wen;
   logic                ren;
   logic                enter_rd;
   logic [AW:0]         cap_new;
   logic [AW:0]         post_sat;
   logic [AW-1:0]       wr_inc;

   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_q == SW'(k)) word = frame_i[k*CH_WIDTH +: CH_WIDTH];
      end
   end

   assign match  = ((word ^ pattern_i) & mask_i) == '0;
   assign wr_inc = wr_ptr_q + 1'b1;

   always_comb begin
      case (trig_mode_i)
         2'd0:    trig = trig_i;
         2'd1:    trig = match;
         2'd2:    trig = trig_i | match;
         default: trig = 1'b1;
      endcase
   end

   always_comb begin
      if (post_len_i == '0)         post_sat = ONE_L;
      else if (post_len_i > DEPTH_L) post_sat = DEPTH_L;
      else                           post_sat = post_len_i;
   end

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      post_d     = post_q;
      pre_d      = pre_q;
      pcnt_d     = pcnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rem_d      = rem_q;
      fetch_d    = fetch_q;
      rd_valid_d = rd_valid_q;
      rd_last_d  = rd_last_q;
      cap_d      = cap_q;
      fec_d      = fec_q;
      wen        = 1'b0;
      ren        = 1'b0;
      enter_rd   = 1'b0;
      cap_new    = '0;

      unique case (state_q)
         S_IDLE: begin
            if (arm_i) begin
               state_d = S_PRE;
               ch_d    = ch_sel_i;
               post_d  = post_sat;
               pre_d   = '0;
               fec_d   = '0;
            end
         end
         S_PRE, S_POST: begin
            if (frame_valid_i) begin
               wen      = 1'b1;
               wr_ptr_d = wr_inc;
               if (fec_i && fec_q != '1) fec_d = fec_q + 1'b1;
               if (state_q == S_POST) begin
                  pcnt_d = pcnt_q + 1'b1;
                  if (pcnt_q + 1'b1 == post_q) begin
                     enter_rd = 1'b1;
                     cap_new  = pre_q + post_q;
                  end
               end else if (trig) begin
                  pcnt_d = ONE_L;
                  if (post_q == ONE_L) begin
                     enter_rd = 1'b1;
                     cap_new  = pre_q + 1'b1;
                  end else begin
                     state_d = S_POST;
                  end
               end else if (pre_q < DEPTH_L - post_q) begin
                  pre_d = pre_q + 1'b1;
               end
            end
         end
         S_READ: begin
            // RAM output register doubles as the output stage; reload on handshake
            if (fetch_q || (rd_valid_q && rd_ready_i && !rd_last_q)) begin
               ren        = 1'b1;
               fetch_d    = 1'b0;
               rd_valid_d = 1'b1;
               rd_last_d  = (rem_q == ONE_L);
               rd_ptr_d   = rd_ptr_q + 1'b1;
               rem_d      = rem_q - 1'b1;
            end else if (rd_valid_q && rd_ready_i) begin
               state_d    = S_IDLE;
               rd_valid_d = 1'b0;
               rd_last_d  = 1'b0;
            end
         end
      endcase

      if (enter_rd) begin
         state_d  = S_READ;
         cap_d    = cap_new;
         rd_ptr_d = wr_inc - cap_new[AW-1:0];
         rem_d    = cap_new;
         fetch_d  = 1'b1;
      end

      if (abort_i) begin
         state_d    = S_IDLE;
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
         fetch_d    = 1'b0;
         cap_d      = cap_q;
         fec_d      = fec_q;
         ren        = 1'b0;
      end
   end

   always_ff @(posedge clk40_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         post_q     <= '0;
         pre_q      <= '0;
         pcnt_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rem_q      <= '0;
         fetch_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         cap_q      <= '0;
         fec_q      <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         post_q     <= post_d;
         pre_q      <= pre_d;
         pcnt_q     <= pcnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rem_q      <= rem_d;
         fetch_q    <= fetch_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         cap_q      <= cap_d;
         fec_q      <= fec_d;
         if (ren) rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk40_i) begin
      if (wen) mem_q[wr_ptr_q] <= word;
   end

   assign rd_data_o     = rd_data_q;
   assign rd_valid_o    = rd_valid_q;
   assign rd_last_o     = rd_last_q;
   assign state_o       = state_q;
   assign capture_len_o = cap_q;
   assign fec_cnt_o     = fec_q;

endmodule
